// File: rtl/hazard_stall_unit.sv
// Stage 3/4 result registers feeding operand forwarding, load-use hazard
// detection and memory-wait freeze with watchdog for the vector pipeline.
module hazard_stall_unit #(
  parameter int unsigned DW      = 128,
  parameter int unsigned RW      = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] id_r2,
  input  logic [RW-1:0] id_r3,
  input  logic [1:0]    id_extnd_sel,
  input  logic          id_vf,
  input  logic [RW-1:0] ex_dest,
  input  logic          ex_vf,
  input  logic          ex_wr,
  input  logic          ex_load,
  input  logic [DW-1:0] ex_res,
  input  logic          flush,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_fe,
  output logic [RW-1:0] fwd_dest3,
  output logic          fwd_vf3,
  output logic [DW-1:0] fwd_res3,
  output logic [RW-1:0] fwd_dest4,
  output logic          fwd_vf4,
  output logic [DW-1:0] fwd_res4,
  output logic          wb_en,
  output logic          mem_err
);

  localparam int unsigned CW = 8;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic          s3_wr;
  logic          s3_load;
  logic          advance;
  logic          forced;
  logic          load_use;
  logic          r2_match;
  logic          r3_match;

  // Load leaving EX whose result the instruction in ID needs next cycle
  assign r2_match = id_extnd_sel[1] && (id_r2 == ex_dest);
  assign r3_match = (id_extnd_sel == 2'b10) && (id_r3 == ex_dest);
  assign load_use = ex_load && ex_wr && (ex_dest != '0) && (ex_vf == id_vf)
                    && (r2_match || r3_match);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= next_state;
  end

  // Next state, pipeline advance and front-end stall
  always_comb begin
    next_state = state;
    advance    = 1'b0;
    forced     = 1'b0;
    stall_fe   = 1'b0;
    case (state)
      ST_RUN: begin
        if (s3_load && s3_wr && !mem_ready) begin
          next_state = ST_WAIT;
          stall_fe   = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          advance    = 1'b1;
          next_state = ST_RUN;
        end else if (wait_cnt >= CW'(TIMEOUT)) begin
          advance    = 1'b1;
          forced     = 1'b1;
          next_state = ST_RUN;
        end else begin
          stall_fe = 1'b1;
        end
      end
      default: next_state = ST_RUN;
    endcase
    // A flushed EX instruction cannot feed a dependent, so no bubble is needed
    if (advance && !flush && load_use) stall_fe = 1'b1;
  end

  // Wait counter starts at 1 on the entry cycle so it counts stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (advance) wait_cnt <= '0;
      else         wait_cnt <= wait_cnt + CW'(1);
      if (forced) mem_err <= 1'b1;
    end
  end

  // Stage 3 (EX/MEM) register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_dest3 <= '0;
      fwd_vf3   <= 1'b0;
      fwd_res3  <= '0;
      s3_wr     <= 1'b0;
      s3_load   <= 1'b0;
    end else if (advance) begin
      fwd_dest3 <= (ex_wr && !flush) ? ex_dest : '0;
      fwd_vf3   <= ex_vf && !flush;
      fwd_res3  <= flush ? '0 : ex_res;
      s3_wr     <= ex_wr && !flush;
      s3_load   <= ex_load && !flush;
    end
  end

  // Stage 4 (MEM/WB) register; a bubble while stage 3 is frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_dest4 <= '0;
      fwd_vf4   <= 1'b0;
      fwd_res4  <= '0;
      wb_en     <= 1'b0;
    end else if (advance) begin
      fwd_dest4 <= fwd_dest3;
      fwd_vf4   <= fwd_vf3;
      if (s3_load) fwd_res4 <= forced ? '0 : mem_rdata;
      else         fwd_res4 <= fwd_res3;
      wb_en     <= s3_wr;
    end else begin
      fwd_dest4 <= '0;
      fwd_vf4   <= 1'b0;
      wb_en     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: forwarding registers, load-use stall,
// memory wait, watchdog timeout, flush and asynchronous reset.
module tb_hazard_stall_unit;

  localparam int unsigned DW = 128;
  localparam int unsigned RW = 4;

  logic          clk;
  logic          rst;
  logic [RW-1:0] id_r2, id_r3, ex_dest;
  logic [1:0]    id_extnd_sel;
  logic          id_vf, ex_vf, ex_wr, ex_load, flush, mem_ready;
  logic [DW-1:0] ex_res, mem_rdata;
  logic          stall_fe, fwd_vf3, fwd_vf4, wb_en, mem_err;
  logic [RW-1:0] fwd_dest3, fwd_dest4;
  logic [DW-1:0] fwd_res3, fwd_res4;

  int vec_cnt = 0;
  int err_cnt = 0;

  hazard_stall_unit #(.DW(DW), .RW(RW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .id_r2(id_r2), .id_r3(id_r3), .id_extnd_sel(id_extnd_sel), .id_vf(id_vf),
    .ex_dest(ex_dest), .ex_vf(ex_vf), .ex_wr(ex_wr), .ex_load(ex_load),
    .ex_res(ex_res), .flush(flush), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_fe(stall_fe),
    .fwd_dest3(fwd_dest3), .fwd_vf3(fwd_vf3), .fwd_res3(fwd_res3),
    .fwd_dest4(fwd_dest4), .fwd_vf4(fwd_vf4), .fwd_res4(fwd_res4),
    .wb_en(wb_en), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_r2 = '0; id_r3 = '0; id_extnd_sel = 2'b00; id_vf = 1'b0;
    ex_dest = '0; ex_vf = 1'b0; ex_wr = 1'b0; ex_load = 1'b0; ex_res = '0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); mem_ready = 1'b1; mem_rdata = '0;
    #3;
    vec_cnt++; if (stall_fe !== 1'b0) begin err_cnt++; $display("FAIL reset_stall: got %b exp 0", stall_fe); end
    vec_cnt++; if (fwd_dest3 !== '0 || fwd_dest4 !== '0) begin err_cnt++; $display("FAIL reset_dest: got %0h/%0h exp 0/0", fwd_dest3, fwd_dest4); end
    vec_cnt++; if (fwd_res3 !== '0 || fwd_res4 !== '0) begin err_cnt++; $display("FAIL reset_res: got %0h/%0h exp 0/0", fwd_res3, fwd_res4); end
    vec_cnt++; if (wb_en !== 1'b0 || mem_err !== 1'b0) begin err_cnt++; $display("FAIL reset_flags: got wb_en=%b mem_err=%b exp 0/0", wb_en, mem_err); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_chain();
    logic [DW-1:0] aa;
    aa = {16{8'hAA}};
    ex_dest = 4'd5; ex_res = aa; ex_wr = 1'b1; ex_vf = 1'b1;
    tick();
    idle();
    vec_cnt++; if (fwd_dest3 !== 4'd5 || fwd_vf3 !== 1'b1) begin err_cnt++; $display("FAIL alu_dest3: got %0h vf=%b exp 5 vf=1", fwd_dest3, fwd_vf3); end
    vec_cnt++; if (fwd_res3 !== aa) begin err_cnt++; $display("FAIL alu_res3: got %0h exp %0h", fwd_res3, aa); end
    tick();
    vec_cnt++; if (fwd_dest4 !== 4'd5 || wb_en !== 1'b1) begin err_cnt++; $display("FAIL alu_dest4: got %0h wb_en=%b exp 5 wb_en=1", fwd_dest4, wb_en); end
    vec_cnt++; if (fwd_res4 !== aa) begin err_cnt++; $display("FAIL alu_res4: got %0h exp %0h", fwd_res4, aa); end
    vec_cnt++; if (fwd_dest3 !== '0) begin err_cnt++; $display("FAIL alu_idle3: got %0h exp 0", fwd_dest3); end
  endtask

  task automatic test_load_use();
    mem_ready = 1'b1; mem_rdata = 128'h55;
    ex_load = 1'b1; ex_wr = 1'b1; ex_dest = 4'd3; ex_vf = 1'b1;
    id_r2 = 4'd3; id_extnd_sel = 2'b10; id_vf = 1'b1;
    #1;
    vec_cnt++; if (stall_fe !== 1'b1) begin err_cnt++; $display("FAIL lu_r2: got %b exp 1", stall_fe); end
    id_vf = 1'b0; #1;
    vec_cnt++; if (stall_fe !== 1'b0) begin err_cnt++; $display("FAIL lu_vf_diff: got %b exp 0", stall_fe); end
    id_vf = 1'b1; id_r2 = 4'd0; ex_dest = 4'd0; #1;
    vec_cnt++; if (stall_fe !== 1'b0) begin err_cnt++; $display("FAIL lu_null_tag: got %b exp 0", stall_fe); end
    id_r2 = 4'd7; id_r3 = 4'd3; ex_dest = 4'd3; #1;
    vec_cnt++; if (stall_fe !== 1'b1) begin err_cnt++; $display("FAIL lu_r3: got %b exp 1", stall_fe); end
    id_extnd_sel = 2'b11; #1;
    vec_cnt++; if (stall_fe !== 1'b0) begin err_cnt++; $display("FAIL lu_r3_unread: got %b exp 0", stall_fe); end
    id_extnd_sel = 2'b10; ex_wr = 1'b0; #1;
    vec_cnt++; if (stall_fe !== 1'b0) begin err_cnt++; $display("FAIL lu_no_wr: got %b exp 0", stall_fe); end
    ex_wr = 1'b1; id_r2 = 4'd3; #1;
    tick();
    // front end supplies a bubble in EX; the load sits in stage 3
    idle(); id_r2 = 4'd3; id_extnd_sel = 2'b10; id_vf = 1'b1;
    #1;
    vec_cnt++; if (stall_fe !== 1'b0) begin err_cnt++; $display("FAIL lu_one_cycle: got %b exp 0", stall_fe); end
    vec_cnt++; if (fwd_dest3 !== 4'd3) begin err_cnt++; $display("FAIL lu_dest3: got %0h exp 3", fwd_dest3); end
    tick();
    vec_cnt++; if (fwd_res4 !== 128'h55 || wb_en !== 1'b1) begin err_cnt++; $display("FAIL lu_load_res4: got %0h wb_en=%b exp 55 wb_en=1", fwd_res4, wb_en); end
    idle(); tick();
  endtask

  task automatic test_mem_wait();
    mem_ready = 1'b1;
    ex_dest = 4'd9; ex_wr = 1'b1; ex_res = 128'h99;
    tick();
    ex_dest = 4'd6; ex_load = 1'b1; ex_res = 128'hFFFF;
    tick();
    ex_dest = 4'd2; ex_load = 1'b0; ex_res = 128'h22;
    mem_ready = 1'b0; mem_rdata = 128'hBAD;
    for (int i = 0; i < 4; i++) begin
      #1;
      vec_cnt++; if (stall_fe !== 1'b1) begin err_cnt++; $display("FAIL wait_stall%0d: got %b exp 1", i, stall_fe); end
      tick();
      vec_cnt++; if (fwd_dest4 !== '0 || wb_en !== 1'b0 || fwd_dest3 !== 4'd6) begin err_cnt++; $display("FAIL wait_bubble%0d: got d4=%0h wb_en=%b d3=%0h exp 0/0/6", i, fwd_dest4, wb_en, fwd_dest3); end
    end
    mem_ready = 1'b1; mem_rdata = 128'h1234;
    #1;
    vec_cnt++; if (stall_fe !== 1'b0) begin err_cnt++; $display("FAIL wait_release: got %b exp 0", stall_fe); end
    tick();
    idle();
    vec_cnt++; if (fwd_dest4 !== 4'd6 || fwd_res4 !== 128'h1234 || wb_en !== 1'b1) begin err_cnt++; $display("FAIL wait_done4: got d4=%0h res=%0h wb_en=%b exp 6/1234/1", fwd_dest4, fwd_res4, wb_en); end
    vec_cnt++; if (fwd_dest3 !== 4'd2 || fwd_res3 !== 128'h22) begin err_cnt++; $display("FAIL wait_done3: got d3=%0h res=%0h exp 2/22", fwd_dest3, fwd_res3); end
    vec_cnt++; if (mem_err !== 1'b0) begin err_cnt++; $display("FAIL wait_no_err: got %b exp 0", mem_err); end
    tick();
  endtask

  task automatic test_flush_hazard();
    mem_ready = 1'b1;
    ex_load = 1'b1; ex_wr = 1'b1; ex_dest = 4'd3; ex_vf = 1'b1; ex_res = 128'h77;
    id_r2 = 4'd3; id_extnd_sel = 2'b10; id_vf = 1'b1; flush = 1'b1;
    #1;
    vec_cnt++; if (stall_fe !== 1'b0) begin err_cnt++; $display("FAIL flush_stall: got %b exp 0", stall_fe); end
    tick();
    idle();
    vec_cnt++; if (fwd_dest3 !== '0) begin err_cnt++; $display("FAIL flush_dest3: got %0h exp 0", fwd_dest3); end
    tick();
    vec_cnt++; if (wb_en !== 1'b0 || fwd_dest4 !== '0) begin err_cnt++; $display("FAIL flush_wb: got wb_en=%b d4=%0h exp 0/0", wb_en, fwd_dest4); end
  endtask

  task automatic test_timeout();
    int stalls;
    mem_ready = 1'b0; mem_rdata = 128'hDEAD;
    ex_load = 1'b1; ex_wr = 1'b1; ex_dest = 4'd4;
    tick();
    idle();
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stall_fe !== 1'b1) break;
      stalls++;
      tick();
    end
    vec_cnt++; if (stalls !== 15) begin err_cnt++; $display("FAIL timeout_cycles: got %0d exp 15", stalls); end
    tick();
    vec_cnt++; if (fwd_dest4 !== 4'd4 || fwd_res4 !== '0 || wb_en !== 1'b1) begin err_cnt++; $display("FAIL timeout_forced: got d4=%0h res=%0h wb_en=%b exp 4/0/1", fwd_dest4, fwd_res4, wb_en); end
    vec_cnt++; if (mem_err !== 1'b1) begin err_cnt++; $display("FAIL timeout_err: got %b exp 1", mem_err); end
    mem_ready = 1'b1;
    tick(); tick(); tick();
    vec_cnt++; if (mem_err !== 1'b1) begin err_cnt++; $display("FAIL timeout_sticky: got %b exp 1", mem_err); end
  endtask

  task automatic test_reset_mid_wait();
    mem_ready = 1'b0;
    ex_load = 1'b1; ex_wr = 1'b1; ex_dest = 4'd8; ex_vf = 1'b1; ex_res = 128'h88;
    tick();
    idle();
    tick(); tick(); tick();
    vec_cnt++; if (stall_fe !== 1'b1) begin err_cnt++; $display("FAIL rmw_in_wait: got %b exp 1", stall_fe); end
    #2 rst = 1'b1;
    #1;
    vec_cnt++; if (stall_fe !== 1'b0 || wb_en !== 1'b0 || mem_err !== 1'b0) begin err_cnt++; $display("FAIL rmw_flags: got stall=%b wb_en=%b err=%b exp 0/0/0", stall_fe, wb_en, mem_err); end
    vec_cnt++; if (fwd_dest3 !== '0 || fwd_vf3 !== 1'b0 || fwd_res3 !== '0) begin err_cnt++; $display("FAIL rmw_stage3: got %0h/%b/%0h exp 0/0/0", fwd_dest3, fwd_vf3, fwd_res3); end
    vec_cnt++; if (fwd_dest4 !== '0 || fwd_vf4 !== 1'b0 || fwd_res4 !== '0) begin err_cnt++; $display("FAIL rmw_stage4: got %0h/%b/%0h exp 0/0/0", fwd_dest4, fwd_vf4, fwd_res4); end
    tick();
    rst = 1'b0;
    ex_dest = 4'd7; ex_wr = 1'b1; ex_res = 128'h7;
    #1;
    vec_cnt++; if (stall_fe !== 1'b0) begin err_cnt++; $display("FAIL rmw_run: got %b exp 0", stall_fe); end
    tick();
    idle();
    vec_cnt++; if (fwd_dest3 !== 4'd7) begin err_cnt++; $display("FAIL rmw_advance: got %0h exp 7", fwd_dest3); end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_mem_wait();
    test_flush_hazard();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
